bfp_denormalization: RTL
========================

Name: bfp_denormalization

Overview:
- Inverse of the block-floating-point normalizer. Takes one BFP block (shared exponent plus four sign+mantissa words) and converts it back to four independent FP16-style words.
- Each element is renormalised through a single shared leading-one/shift datapath, one element per cycle.
- Sits at the output side of the BFP arithmetic path, between the block compute units and FP16 consumers.
- Uses a valid/ready handshake on both sides.

Parameters:
- input_size, 16, width of each reconstructed output word (sign + exponent + mantissa)
- exponent_size, 5, width of the shared and output exponent; bias = 2^(exponent_size-1)-1
- mantissa_size, 10, width of the stored mantissa; each BFP element is mantissa_size+1 bits with the sign at the MSB

Ports:
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  BFP block present on in1..in4 and exponent
- in_ready  output  1  block accepted when in_valid && in_ready
- exponent  input  exponent_size  shared block exponent E
- in1, in2, in3, in4  input  mantissa_size+1  {sign, mantissa m}
- out_valid  output  1  out1..out4 hold a converted block
- out_ready  input  1  consumer takes the block when out_valid && out_ready
- out1, out2, out3, out4  output  input_size  {sign, exp_out, frac}

Behaviour:
- Reset (async, rst=1):
  - state goes to IDLE and the element counter goes to 0.
  - in_ready=0 while rst=1; in_ready=1 on the first clock after release.
  - out_valid=0 and out1..out4=0.
  - Reset mid-conversion or mid-DONE discards the block with no partial output.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On handshake, register E, in1..in4 and the signs, clear counter, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle convert element[counter] and write it to out[counter]; counter++.
  - After element 3, go to DONE.
- DONE:
  - out_valid=1; out1..out4 stable.
  - On out_ready, clear out_valid and go to IDLE.
  - No new block is accepted in the same cycle.
- Latency: handshake at edge N gives out_valid=1 after edge N+4.
- Throughput: at most one block every 6 cycles.
- Per-element conversion (s, m, E):
  - p = index of the leading one of m[mantissa_size-1:0].
  - sh = mantissa_size - p (range 1..mantissa_size).
  - If m==0: output {s, all zeros} (signed zero).
  - Else if E > sh: output {s, E-sh, (m<<sh)[mantissa_size-1:0]} (the hidden one is dropped).
  - Else (E <= sh, underflow): flush to {s, all zeros}, unless the optional feature below is enabled.
- Since sh>=1, exp_out never reaches all-ones; E=all-ones is treated numerically.
- out_valid never asserts while state is IDLE or CONV.
- out1..out4 keep their previous values until overwritten during CONV.

Optional Feature:
- Macro: BFP_SUBNORMAL_EN.
- Defined: the underflow case E <= sh emits a subnormal {s, 0, f}.
  - f = m << (E-1) for E>=1.
  - f = m >> 1 (truncating) for E==0.
- Undefined: underflow flushes to signed zero; the subnormal shifter is not built.

Test Plan:
- E=15, in1=0x200 (s=0, m=512), out_ready=1 -> out1=0x3800, out_valid asserts 4 cycles after the handshake; in1 with s=1 -> 0xB800.
- E=15, in1..in4 = 0x3FF, 0x001, 0x000, 0x400 -> out1..out4 = 0x3BFE, 0x1400, 0x0000, 0x8000.
- Underflow, E=5, in1=0x001:
  - BFP_SUBNORMAL_EN undefined -> out1=0x0000.
  - BFP_SUBNORMAL_EN defined -> out1=0x0010.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout; on out_ready=1, out_valid drops next edge and in_ready=1.
- Assert rst asynchronously during CONV after element 1 -> out_valid=0 and out1..out4=0 immediately; in_ready=1 after release; a fresh block then converts correctly.
- Back-to-back: in_valid held high with two different blocks -> second accepted only after the DONE handshake; each output block matches its own input.

Source files
------------

// File: rtl/bfp_denormalization.sv
// bfp_denormalization: converts one block-floating-point block (shared
// exponent plus four {sign, mantissa} elements) back into four FP16-style
// words {sign, exponent, fraction}. Elements pass one per cycle through a
// single shared leading-one / shift datapath.
//
// Optional feature macro: BFP_SUBNORMAL_EN
//   defined   -> underflowing elements become subnormals {s, 0, f}
//   undefined -> underflowing elements flush to signed zero
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds its data stable while valid is high and
// ready is low. in_ready is high only in IDLE (and low during reset and on
// the first edge after reset). out_valid is high only in DONE, and out1..out4
// stay stable until the consumer takes the block with out_ready.
module bfp_denormalization #(
  parameter int input_size    = 16,
  parameter int exponent_size = 5,
  parameter int mantissa_size = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [exponent_size-1:0] exponent,
  input  logic [mantissa_size:0]   in1,
  input  logic [mantissa_size:0]   in2,
  input  logic [mantissa_size:0]   in3,
  input  logic [mantissa_size:0]   in4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [input_size-1:0]    out1,
  output logic [input_size-1:0]    out2,
  output logic [input_size-1:0]    out3,
  output logic [input_size-1:0]    out4,
  output logic [1:0]               dbg_state_o
);

  localparam int EW  = exponent_size;
  localparam int MW  = mantissa_size;
  localparam int SHW = $clog2(MW + 1);
  // Compare width wide enough for both the exponent and the shift amount.
  localparam int CW  = ((EW > SHW) ? EW : SHW) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  in_ready_q;
  logic [EW-1:0]         exp_q;
  logic [MW:0]           elem_q [4];
  logic [input_size-1:0] out_q  [4];

  logic                  accept;
  logic [MW:0]           elem_sel;
  logic                  s_sel;
  logic [MW-1:0]         m_sel;
  logic [SHW-1:0]        lead_p;
  logic [SHW-1:0]        sh;
  logic [MW-1:0]         frac_norm;
  logic [input_size-1:0] conv_word;
`ifdef BFP_SUBNORMAL_EN
  logic [MW-1:0]         frac_sub;
`endif

  assign accept      = in_valid && in_ready_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == DONE);
  assign dbg_state_o = state_q;
  assign out1        = out_q[0];
  assign out2        = out_q[1];
  assign out3        = out_q[2];
  assign out4        = out_q[3];

  // Element currently being converted, selected by the element counter.
  assign elem_sel = elem_q[cnt_q];
  assign s_sel    = elem_sel[MW];
  assign m_sel    = elem_sel[MW-1:0];

  // Leading-one position of the mantissa; ascending scan so the highest set bit wins.
  always_comb begin
    lead_p = '0;
    for (int i = 0; i < MW; i++) begin
      if (m_sel[i]) lead_p = SHW'(i);
    end
  end

  // Shift that moves the leading one into the hidden-bit position (1..MW).
  assign sh        = SHW'(MW) - lead_p;
  assign frac_norm = m_sel << sh;

`ifdef BFP_SUBNORMAL_EN
  // Subnormal fraction: E-1 keeps the value exact for E>=1; E==0 truncates.
  always_comb begin
    frac_sub = '0;
    if (exp_q == '0) frac_sub = m_sel >> 1;
    else             frac_sub = m_sel << (exp_q - 1'b1);
  end
`endif

  // Per-element conversion: signed zero, normal result, or underflow handling.
  always_comb begin
    conv_word = {s_sel, {(input_size-1){1'b0}}};
    if (m_sel == '0) begin
      conv_word = {s_sel, {(input_size-1){1'b0}}};
    end else if (CW'(exp_q) > CW'(sh)) begin
      conv_word = {s_sel, exp_q - EW'(sh), frac_norm};
    end else begin
`ifdef BFP_SUBNORMAL_EN
      conv_word = {s_sel, {EW{1'b0}}, frac_sub};
`else
      conv_word = {s_sel, {(input_size-1){1'b0}}};
`endif
    end
  end

  // Next-state logic for the IDLE -> CONV -> DONE sequence and element counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CONV;
          cnt_d   = 2'd0;
        end
      end
      CONV: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Control registers; in_ready tracks IDLE but is held low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  // Input capture on the accepting handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      for (int i = 0; i < 4; i++) elem_q[i] <= '0;
    end else if (accept) begin
      exp_q     <= exponent;
      elem_q[0] <= in1;
      elem_q[1] <= in2;
      elem_q[2] <= in3;
      elem_q[3] <= in4;
    end
  end

  // Output words: one element written per CONV cycle, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else if (state_q == CONV) begin
      out_q[cnt_q] <= conv_word;
    end
  end

endmodule
